// File: rtl/spi_slave_word_packer.sv
// Packs a received SPI byte stream into 16-bit words, buffers them in a small FIFO
// and drains them to the SRAM FIFO controller over its write/hint handshake.
module spi_slave_word_packer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [7:0]  PAD_BYTE = 8'h00,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  input  logic                     pkt_end,
  output logic                     slave_write,
  output logic [15:0]              slave_data_to_sram,
  input  logic                     slave_hint,
  output logic [$clog2(DEPTH):0]   buf_count,
  output logic                     busy,
  output logic                     overflow,
  output logic [CNT_W-1:0]         words_written
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  state_e            state_q;
  logic [7:0]        hi_q;
  logic              partial_q;
  logic              pend_q;
  logic [15:0]       pend_word_q;
  logic [15:0]       mem [DEPTH];
  logic [PtrW-1:0]   wptr_q;
  logic [PtrW-1:0]   rptr_q;
  logic [PtrW:0]     count_q;
  logic              write_q;
  logic [15:0]       data_q;
  logic              overflow_q;
  logic [CNT_W-1:0]  words_q;

  logic full;
  logic push;
  logic pop;

  always_comb begin
    full = (count_q == FullCount);
    push = pend_q && !full;
    pop  = (state_q == StReq) && slave_hint;
  end

  // Byte pairing; a completed word sits in pend_word_q for one cycle before the push.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q        <= 8'h00;
      partial_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_word_q <= 16'h0000;
    end else begin
      pend_q <= 1'b0;
      if (byte_valid) begin
        if (partial_q) begin
          pend_word_q <= {hi_q, byte_in};
          pend_q      <= 1'b1;
          partial_q   <= 1'b0;
        end else if (pkt_end) begin
          pend_word_q <= {byte_in, PAD_BYTE};
          pend_q      <= 1'b1;
          partial_q   <= 1'b0;
        end else begin
          hi_q      <= byte_in;
          partial_q <= 1'b1;
        end
      end else if (pkt_end && partial_q) begin
        pend_word_q <= {hi_q, PAD_BYTE};
        pend_q      <= 1'b1;
        partial_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= pend_word_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pend_q && full) begin
        overflow_q <= 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // GAP also makes the next IDLE decision so back-to-back words see a single low cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      data_q  <= 16'h0000;
      words_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            data_q  <= mem[rptr_q];
            write_q <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (slave_hint) begin
            write_q <= 1'b0;
            words_q <= words_q + 1'b1;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (count_q != '0) begin
            data_q  <= mem[rptr_q];
            write_q <= 1'b1;
            state_q <= StReq;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          write_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // A word waiting in pend_q still counts as held data for busy.
  always_comb begin
    slave_write        = write_q;
    slave_data_to_sram = data_q;
    buf_count          = count_q;
    overflow           = overflow_q;
    words_written      = words_q;
    busy               = (count_q != '0) || partial_q || pend_q || write_q;
  end

endmodule
